// File: rtl/ann_pkg.sv
// Shared fixed-point constants and FSM encoding for the ANN neuron datapath stages.
package ann_pkg;

  localparam int unsigned DATA_W           = 16;
  localparam int unsigned FRAC_BITS        = 8;
  localparam int unsigned ACC_W            = 40;
  localparam int unsigned PROD_W           = 2 * DATA_W;
  localparam int unsigned N_INPUTS_DEFAULT = 28;

  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_mac_engine_if.sv
// Activation stream, weight BRAM port and result stream of one neuron MAC engine.
interface neuron_mac_engine_if #(
  parameter int unsigned ADDR_W = 5
);
  import ann_pkg::*;

  logic [DATA_W-1:0] X_DATA;
  logic              X_VALID;
  logic              X_READY;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic              W_WE;
  logic [DATA_W-1:0] W_DO;
  logic [DATA_W-1:0] Y_DATA;
  logic              Y_VALID;
  logic              Y_READY;

  // Environment side: activation source, weight BRAM and result sink.
  modport master (
    output X_DATA, X_VALID, W_DO, Y_READY,
    input  X_READY, W_ADDR, W_EN, W_WE, Y_DATA, Y_VALID
  );

  // Engine side.
  modport slave (
    input  X_DATA, X_VALID, W_DO, Y_READY,
    output X_READY, W_ADDR, W_EN, W_WE, Y_DATA, Y_VALID
  );

endinterface

// File: rtl/q_sat_relu.sv
// Combinational Q-format rescale: arithmetic shift, saturate to DATA_W, optional ReLU.
module q_sat_relu
  import ann_pkg::*;
#(
  parameter int unsigned RELU = 1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] y_c
);

  localparam int unsigned HI_W = ACC_W - DATA_W + 1;

  logic signed [ACC_W-1:0] shifted;
  logic        [HI_W-1:0]  hi;

  // Value fits in DATA_W when every bit above the result's sign bit matches it.
  always_comb begin
    shifted = acc >>> FRAC_BITS;
    hi      = shifted[ACC_W-1:DATA_W-1];
    if ((hi == '0) || (hi == '1)) begin
      y_c = shifted[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      y_c = Q_MIN;
    end else begin
      y_c = Q_MAX;
    end
    if ((RELU != 0) && y_c[DATA_W-1]) begin
      y_c = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_engine.sv
// Single-neuron multiply-accumulate engine fed by an activation stream and a
// falling-edge weight BRAM; emits one saturated (optionally ReLU'd) Q8.8 result.
module neuron_mac_engine
  import ann_pkg::*;
#(
  parameter int unsigned N_INPUTS = N_INPUTS_DEFAULT,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RELU     = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  output logic                BUSY,
  neuron_mac_engine_if.slave  bus
);

  localparam int unsigned IDX_W = ADDR_W + 1;

  state_t                    state, state_d;
  logic [IDX_W-1:0]          idx, idx_d;
  logic                      busy_d, x_ready_d, y_valid_d;
  logic                      load_y, clr_acc, accept;
  logic                      s1_valid, p_valid;
  logic [DATA_W-1:0]         x_reg;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         y_sat;

  assign accept   = (state == ACCUM) && bus.X_VALID && bus.X_READY;
  assign bus.W_WE = 1'b0;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    busy_d    = BUSY;
    x_ready_d = bus.X_READY;
    y_valid_d = bus.Y_VALID;
    load_y    = 1'b0;
    clr_acc   = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_d   = ACCUM;
          idx_d     = '0;
          busy_d    = 1'b1;
          x_ready_d = 1'b1;
          clr_acc   = 1'b1;
        end
      end
      ACCUM: begin
        if (accept) begin
          idx_d = idx + IDX_W'(1);
          if (idx == IDX_W'(N_INPUTS - 1)) begin
            x_ready_d = 1'b0;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!s1_valid && !p_valid) begin
          load_y    = 1'b1;
          y_valid_d = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (bus.Y_READY) begin
          y_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      idx         <= '0;
      BUSY        <= 1'b0;
      bus.X_READY <= 1'b0;
      bus.Y_VALID <= 1'b0;
      bus.Y_DATA  <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      BUSY        <= busy_d;
      bus.X_READY <= x_ready_d;
      bus.Y_VALID <= y_valid_d;
      if (load_y) begin
        bus.Y_DATA <= y_sat;
      end
    end
  end

  // Two-stage MAC: weight arrives one cycle after the accept, product then accumulates.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_reg      <= '0;
      bus.W_ADDR <= '0;
      bus.W_EN   <= 1'b0;
      s1_valid   <= 1'b0;
      p_valid    <= 1'b0;
      prod       <= '0;
      acc        <= '0;
    end else begin
      bus.W_EN <= accept;
      s1_valid <= accept;
      p_valid  <= s1_valid;
      if (accept) begin
        x_reg      <= bus.X_DATA;
        bus.W_ADDR <= ADDR_W'(idx);
      end
      if (s1_valid) begin
        prod <= PROD_W'($signed(x_reg)) * PROD_W'($signed(bus.W_DO));
      end
      if (clr_acc) begin
        acc <= '0;
      end else if (p_valid) begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

  q_sat_relu #(
    .RELU (RELU)
  ) u_sat (
    .acc (acc),
    .y_c (y_sat)
  );

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Scoreboard bench: two engines (ReLU on / off) share stimulus and a weight image.
module tb_neuron_mac_engine;

  localparam int unsigned N = 28;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        x_valid = 1'b0;
  logic        y_ready = 1'b0;
  logic [15:0] x_data  = '0;
  logic        busy1, busy0;

  logic [15:0] wt  [N];
  logic [15:0] act [N];

  logic [15:0] exp_q1[$];
  logic [15:0] exp_q0[$];
  logic [4:0]  addr_q[$];

  int cyc      = 0;
  int hs_cnt   = 0;
  int xr_viol  = 0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_mac_engine_if #(.ADDR_W(5)) bus1 ();
  neuron_mac_engine_if #(.ADDR_W(5)) bus0 ();

  assign bus1.X_DATA  = x_data;
  assign bus1.X_VALID = x_valid;
  assign bus1.Y_READY = y_ready;
  assign bus0.X_DATA  = x_data;
  assign bus0.X_VALID = x_valid;
  assign bus0.Y_READY = y_ready;

  neuron_mac_engine #(.N_INPUTS(N), .ADDR_W(5), .RELU(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start), .BUSY(busy1), .bus(bus1)
  );
  neuron_mac_engine #(.N_INPUTS(N), .ADDR_W(5), .RELU(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start), .BUSY(busy0), .bus(bus0)
  );

  // Weight BRAMs sample the address on the falling edge.
  always @(negedge clk) begin
    if (bus1.W_EN) bus1.W_DO <= wt[bus1.W_ADDR];
    if (bus0.W_EN) bus0.W_DO <= wt[bus0.W_ADDR];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus1.W_EN) addr_q.push_back(bus1.W_ADDR);
    if (rst_n && bus1.Y_VALID && y_ready) hs_cnt <= hs_cnt + 1;
    if (bus1.X_READY && (!busy1 || bus1.Y_VALID)) xr_viol <= xr_viol + 1;
  end

  function automatic logic [15:0] model(input bit relu);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'($signed(act[i])) * longint'($signed(wt[i]));
    r = acc >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  task automatic fill(input logic [15:0] w, input logic [15:0] a);
    for (int i = 0; i < N; i++) begin
      wt[i]  = w;
      act[i] = a;
    end
  endtask

  task automatic run_neuron(input string name, input bit alt_valid, input int stall,
                            input bit early_ready, input bit start_noise);
    int n, t0, waitc, p, hs0, bad;
    logic [15:0] e1, e0, hold1, hold0;
    exp_q1.push_back(model(1'b1));
    exp_q0.push_back(model(1'b0));
    addr_q.delete();
    hs0     = hs_cnt;
    y_ready = early_ready;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    n = 0; p = 0; waitc = 0;
    while (n < N && waitc < 400) begin
      x_valid = alt_valid ? p[0] : 1'b1;
      p++;
      x_data = act[n];
      start  = (start_noise && n == 5);
      if (x_valid && bus1.X_READY) n++;
      @(negedge clk);
      waitc++;
    end
    x_valid = 1'b0;
    start   = 1'b0;
    checks++;
    if (n != N) begin
      failures++;
      $display("FAIL %s accepts: got %0d expected %0d", name, n, N);
    end
    waitc = 0;
    while (!bus1.Y_VALID && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (!bus1.Y_VALID || !bus0.Y_VALID) begin
      failures++;
      $display("FAIL %s y_valid timeout: got %b/%b expected 1/1", name, bus1.Y_VALID, bus0.Y_VALID);
      void'(exp_q1.pop_front());
      void'(exp_q0.pop_front());
      return;
    end
    if (!alt_valid) begin
      checks++;
      if (cyc !== t0 + N + 3) begin
        failures++;
        $display("FAIL %s latency: got edge t0+%0d expected t0+%0d", name, cyc - t0, N + 3);
      end
    end
    hold1 = bus1.Y_DATA;
    hold0 = bus0.Y_DATA;
    if (!early_ready) begin
      for (int i = 0; i < stall; i++) begin
        start = (start_noise && i == 2);
        @(negedge clk);
        checks++;
        if (!bus1.Y_VALID || bus1.Y_DATA !== hold1 || bus0.Y_DATA !== hold0) begin
          failures++;
          $display("FAIL %s stall hold: got valid=%b data=%h/%h expected 1 %h/%h",
                   name, bus1.Y_VALID, bus1.Y_DATA, bus0.Y_DATA, hold1, hold0);
        end
      end
      start = 1'b0;
    end
    e1 = exp_q1.pop_front();
    e0 = exp_q0.pop_front();
    checks++;
    if (bus1.Y_DATA !== e1) begin
      failures++;
      $display("FAIL %s y_data relu1: got %h expected %h", name, bus1.Y_DATA, e1);
    end
    checks++;
    if (bus0.Y_DATA !== e0) begin
      failures++;
      $display("FAIL %s y_data relu0: got %h expected %h", name, bus0.Y_DATA, e0);
    end
    y_ready = 1'b1;
    start   = start_noise;
    @(negedge clk);
    start   = 1'b0;
    y_ready = 1'b0;
    checks++;
    if (bus1.Y_VALID !== 1'b0 || busy1 !== 1'b0 || bus0.Y_VALID !== 1'b0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL %s done: got valid=%b busy=%b expected 0 0", name, bus1.Y_VALID, busy1);
    end
    if (start_noise) begin
      repeat (3) @(negedge clk);
      checks++;
      if (busy1 !== 1'b0) begin
        failures++;
        $display("FAIL %s start_at_done: got busy=%b expected 0", name, busy1);
      end
    end
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] !== 5'(i)) bad++;
    checks++;
    if (addr_q.size() != N || bad != 0) begin
      failures++;
      $display("FAIL %s w_addr: got %0d pulses %0d misordered expected %0d 0", name, addr_q.size(), bad, N);
    end
    checks++;
    if (hs_cnt - hs0 != 1) begin
      failures++;
      $display("FAIL %s results: got %0d expected 1", name, hs_cnt - hs0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, bus1.X_READY, bus1.W_EN, bus1.W_WE, bus1.Y_VALID} !== 5'b0) begin
      failures++;
      $display("FAIL reset ctl: got %b expected 00000",
               {busy1, bus1.X_READY, bus1.W_EN, bus1.W_WE, bus1.Y_VALID});
    end
    checks++;
    if (bus1.W_ADDR !== 5'd0 || bus1.Y_DATA !== 16'h0 || bus0.Y_DATA !== 16'h0) begin
      failures++;
      $display("FAIL reset data: got addr=%h y=%h expected 0 0", bus1.W_ADDR, bus1.Y_DATA);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unity;
    fill(16'h0100, 16'h0100);
    run_neuron("unity", 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation;
    fill(16'h7FFF, 16'h7FFF);
    run_neuron("sat_pos", 1'b0, 2, 1'b0, 1'b0);
    fill(16'h8000, 16'h7FFF);
    run_neuron("sat_neg", 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_negative;
    fill(16'hFF00, 16'h0200);
    run_neuron("negative", 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    fill(16'h0100, 16'h0100);
    run_neuron("stall", 1'b1, 5, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      wt[i]  = 16'($urandom_range(0, 16'hFFFF));
      act[i] = 16'($urandom_range(0, 16'hFFFF));
    end
    run_neuron("random", 1'b1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort;
    int n, guard, seen;
    fill(16'h0100, 16'h0100);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    x_valid = 1'b1;
    x_data  = 16'h0100;
    n = 0; guard = 0;
    while (n < 10 && guard < 50) begin
      if (bus1.X_READY) n++;
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, bus1.Y_VALID, bus1.W_EN, bus1.X_READY, busy0} !== 5'b0) begin
      failures++;
      $display("FAIL abort: got busy/yv/wen/xr=%b expected 00000",
               {busy1, bus1.Y_VALID, bus1.W_EN, bus1.X_READY, busy0});
    end
    rst_n   = 1'b1;
    x_valid = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.Y_VALID || bus0.Y_VALID) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort partial result: got %0d valid cycles expected 0", seen);
    end
    run_neuron("after_reset", 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_noise;
    fill(16'h0100, 16'h0100);
    run_neuron("start_noise", 1'b0, 4, 1'b0, 1'b1);
    checks++;
    if (xr_viol != 0) begin
      failures++;
      $display("FAIL x_ready outside accum: got %0d cycles expected 0", xr_viol);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_saturation();
    test_negative();
    test_stall();
    test_reset_abort();
    test_start_noise();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
